iic_driver: RTL and testbench

- SCCB/I2C master for single-register access to a camera sensor (OV-style SCCB slave).
- A one-cycle `wr_en` pulse performs a 3-phase write: device address (W), register address, data.
- A one-cycle `rd_en` pulse performs a 2-phase write (device address W, register address), then STOP, then a 2-phase read (device address R, data byte with master NACK).
- Sits between the camera configuration/checker controllers and the sensor's SIO_C/SIO_D pins.

---
 rtl/iic_driver.sv | 200 ++++++++++++++++++++
 tb/tb_iic_driver.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iic_driver.sv
// iic_driver: SCCB/I2C master performing one register write or read per request.
// Build option IIC_NACK_ABORT_EN: a slave NACK ends the transaction with an immediate STOP.
module iic_driver #(
  parameter int unsigned CLK_DIV  = 125,
  parameter logic [7:0]  DEV_ADDR = 8'h42
) (
  input  logic        clk,
  input  logic        rst,
  output logic        scl,
  inout  wire         sda,
  input  logic        wr_en,
  input  logic        rd_en,
  input  logic [7:0]  addr,
  input  logic [7:0]  wr_data,
  output logic        work_done,
  output logic        ack,
  output logic [7:0]  rd_data,
  output logic [31:0] debug_out
);

  // IDLE: wait for request        | START: SDA falls, SCL high
  // SEND_BYTE: master shifts out  | SLAVE_ACK: sample slave ACK
  // RECV_BYTE: master shifts in   | MASTER_NACK: SDA released 9th slot
  // STOP: SDA low, SCL up, SDA up | GAP: bus-free time before repeated START
  typedef enum logic [2:0] {
    IDLE, START, SEND_BYTE, SLAVE_ACK, RECV_BYTE, MASTER_NACK, STOP, GAP
  } state_t;

  localparam int unsigned TW = $clog2(CLK_DIV);
  localparam logic [TW-1:0] TICK_MAX = TW'(CLK_DIV - 1);

`ifdef IIC_NACK_ABORT_EN
  localparam bit NACK_ABORT = 1'b1;
`else
  localparam bit NACK_ABORT = 1'b0;
`endif

  state_t        state;
  logic [TW-1:0] tick;
  logic [1:0]    q;
  logic [2:0]    bit_cnt;
  logic [1:0]    byte_idx;
  logic [7:0]    shreg;
  logic [7:0]    addr_q;
  logic [7:0]    data_q;
  logic          is_rd;
  logic          rd_phase;
  logic          ack_acc;
  logic          sda_oe;
  logic          sda_in;
  logic          strobe;
  logic          aborted;

  assign sda     = sda_oe ? 1'b0 : 1'bz;
  assign sda_in  = sda;
  assign strobe  = (state != IDLE) && (tick == '0);
  // With abort enabled the first NACK leaves the sequence, so a cleared accumulator marks an abort.
  assign aborted = NACK_ABORT && !ack_acc;

  assign debug_out = {5'b0, state, shreg, rd_data, 1'b0, bit_cnt,
                      state != IDLE, sda_in, scl, ack};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      tick      <= TICK_MAX;
      q         <= '0;
      bit_cnt   <= '0;
      byte_idx  <= '0;
      shreg     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      is_rd     <= 1'b0;
      rd_phase  <= 1'b0;
      ack_acc   <= 1'b0;
      sda_oe    <= 1'b0;
      scl       <= 1'b1;
      work_done <= 1'b0;
      ack       <= 1'b0;
      rd_data   <= '0;
    end else begin
      if (state == IDLE || tick == '0) tick <= TICK_MAX;
      else                             tick <= tick - 1'b1;

      unique case (state)
        IDLE: begin
          if (rd_en || wr_en) begin
            is_rd     <= rd_en;
            addr_q    <= addr;
            data_q    <= wr_data;
            work_done <= 1'b0;
            ack_acc   <= 1'b1;
            rd_phase  <= 1'b0;
            q         <= '0;
            state     <= START;
          end
        end

        START: begin
          if (strobe) begin
            sda_oe   <= 1'b1;
            shreg    <= rd_phase ? (DEV_ADDR | 8'h01) : DEV_ADDR;
            byte_idx <= '0;
            bit_cnt  <= '0;
            q        <= '0;
            state    <= SEND_BYTE;
          end
        end

        SEND_BYTE, SLAVE_ACK, RECV_BYTE, MASTER_NACK: begin
          if (strobe) begin
            q <= q + 2'd1;
            case (q)
              2'd0: begin
                scl    <= 1'b0;
                sda_oe <= (state == SEND_BYTE) ? !shreg[7] : 1'b0;
              end
              2'd1: scl <= 1'b1;
              2'd2: begin
                if (state == SEND_BYTE || state == RECV_BYTE)
                  shreg <= {shreg[6:0], sda_in};
                else if (state == SLAVE_ACK && sda_in)
                  ack_acc <= 1'b0;
              end
              default: begin
                scl <= 1'b0;
                case (state)
                  SEND_BYTE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= SLAVE_ACK;
                  end
                  RECV_BYTE: begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) state <= MASTER_NACK;
                  end
                  MASTER_NACK: state <= STOP;
                  SLAVE_ACK: begin
                    if (aborted)
                      state <= STOP;
                    else if (is_rd && rd_phase)
                      state <= RECV_BYTE;
                    else if ((is_rd && byte_idx == 2'd1) || (!is_rd && byte_idx == 2'd2))
                      state <= STOP;
                    else begin
                      byte_idx <= byte_idx + 2'd1;
                      shreg    <= (byte_idx == 2'd0) ? addr_q : data_q;
                      state    <= SEND_BYTE;
                    end
                  end
                  default: ;
                endcase
              end
            endcase
          end
        end

        STOP: begin
          if (q == 2'd3) begin
            if (is_rd && !aborted) rd_data <= shreg;
            ack       <= ack_acc;
            work_done <= 1'b1;
            q         <= '0;
            state     <= IDLE;
          end else if (strobe) begin
            case (q)
              2'd0: begin
                sda_oe <= 1'b1;
                q      <= 2'd1;
              end
              2'd1: begin
                scl <= 1'b1;
                q   <= 2'd2;
              end
              default: begin
                sda_oe <= 1'b0;
                if (is_rd && !rd_phase && !aborted) begin
                  rd_phase <= 1'b1;
                  q        <= '0;
                  state    <= GAP;
                end else begin
                  q <= 2'd3;
                end
              end
            endcase
          end
        end

        GAP: begin
          if (strobe) begin
            q <= q + 2'd1;
            if (q == 2'd3) state <= START;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iic_driver.sv
// Bench for iic_driver: SCCB slave model feeding bus-token and result scoreboards.
`timescale 1ns/1ps
module tb_iic_driver;

  localparam int CLK_DIV = 4;
  localparam int WR_LAT  = (1 + 27*4 + 3) * CLK_DIV + 1;
  localparam int AB_LAT  = (1 + 18*4 + 3) * CLK_DIV + 1;
  localparam int T_START = 256;
  localparam int T_STOP  = 257;
  localparam int T_NACK  = 300;
  localparam int T_MACK  = 301;

`ifdef IIC_NACK_ABORT_EN
  localparam bit ABORT = 1'b1;
`else
  localparam bit ABORT = 1'b0;
`endif

  typedef struct {
    logic       ack;
    logic [7:0] rd;
    int         lat;
  } res_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [7:0]  addr = 8'h00;
  logic [7:0]  wr_data = 8'h00;
  wire         scl;
  wire         work_done;
  wire         ack;
  wire [7:0]   rd_data;
  wire [31:0]  debug_out;
  wire         sda_bus;
  logic        slv_low = 1'b0;

  assign sda_bus = slv_low ? 1'b0 : 1'bz;
  pullup (sda_bus);

  iic_driver #(.CLK_DIV(CLK_DIV), .DEV_ADDR(8'h42)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda(sda_bus),
    .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wr_data(wr_data),
    .work_done(work_done), .ack(ack), .rd_data(rd_data), .debug_out(debug_out)
  );

  always #5 clk = ~clk;

  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  int   acc_cyc = 0;
  int   rel_cyc = 0;
  bit   bus_chk_en = 1'b1;
  int   nack_idx = -1;
  logic [7:0] slv_tx = 8'h00;
  int   exp_bus[$];
  res_t exp_res[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  task automatic obs(input int tok);
    int e;
    if (bus_chk_en) begin
      checks++;
      if (exp_bus.size() == 0) begin
        errors++;
        $display("FAIL bus_token: got %0h, required none", tok);
      end else begin
        e = exp_bus.pop_front();
        if (tok != e) begin
          errors++;
          $display("FAIL bus_token: got %0h, required %0h", tok, e);
        end
      end
    end
  endtask

  // Slave model: decodes START/STOP and bytes, ACKs, returns slv_tx on reads.
  logic scl_q = 1'b1, sda_q = 1'b1;
  int   bitcnt = 0, bytecnt = 0;
  bit   in_xfer = 1'b0, rd_mode = 1'b0;
  logic [7:0] sh = 8'h00;

  always @(scl or sda_bus) begin
    if (scl !== scl_q) begin
      if (scl === 1'b1 && in_xfer) begin
        if (bitcnt < 8) begin
          if (!(rd_mode && bytecnt > 0)) sh = {sh[6:0], sda_bus === 1'b1};
        end else if (rd_mode && bytecnt > 0) begin
          obs((sda_bus === 1'b1) ? T_NACK : T_MACK);
        end
        bitcnt++;
      end else if (scl === 1'b0 && in_xfer) begin
        if (bitcnt == 9) begin
          bitcnt = 0;
          bytecnt++;
          slv_low = (rd_mode && bytecnt == 1) ? !slv_tx[7] : 1'b0;
        end else if (rd_mode && bytecnt > 0) begin
          slv_low = (bitcnt < 8) ? !slv_tx[7-bitcnt] : 1'b0;
        end else if (bitcnt == 8) begin
          if (bytecnt == 0) rd_mode = sh[0];
          obs(int'(sh));
          slv_low = (bytecnt != nack_idx);
        end
      end
    end else if (sda_bus !== sda_q && scl === 1'b1) begin
      if (sda_bus === 1'b0) begin
        obs(T_START);
        in_xfer = 1'b1;
        bitcnt  = 0;
        bytecnt = 0;
        rd_mode = 1'b0;
      end else if (in_xfer) begin
        obs(T_STOP);
        in_xfer = 1'b0;
        slv_low = 1'b0;
      end
    end
    scl_q = scl;
    sda_q = sda_bus;
  end

  // Result monitor: pops the expected completion whenever work_done rises.
  logic wd_prev = 1'b0, sda_prev = 1'b1;
  always @(negedge clk) begin
    res_t e;
    if (sda_prev === 1'b0 && sda_bus === 1'b1) rel_cyc = cyc;
    if (work_done === 1'b1 && wd_prev !== 1'b1) begin
      if (exp_res.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done_unexpected: got work_done=1, required no completion");
      end else begin
        e = exp_res.pop_front();
        chk("ack", ack, e.ack);
        chk("rd_data", rd_data, e.rd);
        chk("done_after_release", cyc - rel_cyc, 1);
        if (e.lat != 0) chk("wr_latency", cyc - acc_cyc, e.lat);
      end
    end
    sda_prev = sda_bus;
    wd_prev  = work_done;
  end

  task automatic exp_wr(input logic [7:0] a, input logic [7:0] d, input bit nk,
                        input logic eack, input logic [7:0] erd);
    exp_bus.push_back(T_START);
    exp_bus.push_back(8'h42);
    exp_bus.push_back(a);
    if (!(ABORT && nk)) exp_bus.push_back(d);
    exp_bus.push_back(T_STOP);
    exp_res.push_back('{ack: eack, rd: erd, lat: (ABORT && nk) ? AB_LAT : WR_LAT});
  endtask

  task automatic exp_rd(input logic [7:0] a, input bit nk, input logic eack, input logic [7:0] erd);
    exp_bus.push_back(T_START);
    exp_bus.push_back(8'h42);
    exp_bus.push_back(a);
    exp_bus.push_back(T_STOP);
    if (!(ABORT && nk)) begin
      exp_bus.push_back(T_START);
      exp_bus.push_back(8'h43);
      exp_bus.push_back(T_NACK);
      exp_bus.push_back(T_STOP);
    end
    exp_res.push_back('{ack: eack, rd: erd, lat: 0});
  endtask

  task automatic req(input bit rd, input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    rd_en   = rd;
    wr_en   = !rd;
    addr    = a;
    wr_data = d;
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (work_done !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (work_done !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: got work_done=%b after %0d clks, required 1", name, work_done, n);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("rst_scl", scl, 1);
    chk("rst_sda", sda_bus, 1);
    chk("rst_work_done", work_done, 0);
    chk("rst_ack", ack, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_state", debug_out[31:24], 0);
    chk("rst_bitcnt", debug_out[7:4], 0);

    exp_wr(8'h12, 8'h80, 1'b0, 1'b1, 8'h00);
    req(1'b0, 8'h12, 8'h80);
    wait_done("wr1");

    slv_tx = 8'h7f;
    exp_rd(8'h1d, 1'b0, 1'b1, 8'h7f);
    req(1'b1, 8'h1d, 8'h00);
    wait_done("rd1");

    slv_tx = 8'ha5;
    exp_rd(8'h0a, 1'b0, 1'b1, 8'ha5);
    req(1'b1, 8'h0a, 8'h00);
    chk("wd_low_next_clk", work_done, 0);
    @(negedge clk);
    wr_en   = 1'b1;
    addr    = 8'hee;
    wr_data = 8'hff;
    repeat (100) @(negedge clk);
    wr_en = 1'b0;
    wait_done("rd_busy");
    repeat (20) @(negedge clk);
    chk("wd_held", work_done, 1);

    nack_idx = 1;
    exp_wr(8'h33, 8'h55, 1'b1, 1'b0, 8'ha5);
    req(1'b0, 8'h33, 8'h55);
    wait_done("wr_nack");

    slv_tx = 8'h3c;
    exp_rd(8'h5a, 1'b1, 1'b0, ABORT ? 8'ha5 : 8'h3c);
    req(1'b1, 8'h5a, 8'h00);
    wait_done("rd_nack");

    nack_idx = -1;
    exp_wr(8'h12, 8'h80, 1'b0, 1'b1, ABORT ? 8'ha5 : 8'h3c);
    req(1'b0, 8'h12, 8'h80);
    wait_done("wr2");

    bus_chk_en = 1'b0;
    req(1'b1, 8'h77, 8'h00);
    repeat (20) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_scl", scl, 1);
    chk("midrst_sda", sda_bus, 1);
    chk("midrst_work_done", work_done, 0);
    chk("midrst_rd_data", rd_data, 0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    bus_chk_en = 1'b1;

    slv_tx = 8'hc3;
    exp_rd(8'h1d, 1'b0, 1'b1, 8'hc3);
    req(1'b1, 8'h1d, 8'h00);
    wait_done("rd_after_rst");

    chk("bus_queue_empty", exp_bus.size(), 0);
    chk("res_queue_empty", exp_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
